raster_pixel_feeder: RTL
========================

Name: raster_pixel_feeder

Overview:
- Write-side producer for the Sobel row buffering stage.
- Reads a WIDTH x HEIGHT frame in raster order from a 1-cycle-latency synchronous frame RAM and drives the pixel stream (data_out, shift_en) into the row line-buffer manager.
- Tracks the row/column of every pushed pixel and flags pushes that complete a full 3x3 window.
- Honours downstream back-pressure through a 2-entry skid buffer; sustains 1 pixel/cycle when not stalled.

Parameters:
- WIDTH, 100, pixels per row (>= 3)
- HEIGHT, 100, rows per frame (>= 3)
- DATA_WIDTH, 8, bits per pixel
- ADDR_WIDTH, $clog2(WIDTH*HEIGHT), frame RAM address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- stall  in  1  downstream back-pressure; no push while high
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_WIDTH  RAM read address
- mem_rd_data  in  DATA_WIDTH  RAM data, valid the cycle after mem_rd_en
- shift_en  out  1  pixel push strobe to line buffers
- data_out  out  DATA_WIDTH  pixel being pushed
- col  out  $clog2(WIDTH)  column of the head pixel
- row  out  $clog2(HEIGHT)  row of the head pixel
- window_valid  out  1  push completes a 3x3 window
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (the cycle after rst is sampled high): state IDLE, read address counter 0, skid FIFO empty (occ=0), in-flight flag 0, col/row 0. All outputs are 0.
- Reset mid-frame: the in-flight read is discarded, no shift_en on the following cycle, and the next start restarts from address 0.
- N = WIDTH*HEIGHT. State machine:
  - IDLE: start=1 -> RUN; address counter = 0.
  - RUN: issue reads; after the read of address N-1 is issued -> DRAIN.
  - DRAIN: -> DONE when in-flight = 0 and (occ = 0, or occ = 1 with shift_en this cycle).
  - DONE: done = 1 for exactly one cycle -> IDLE.
  - start is ignored outside IDLE.
- Read issue (RUN only):
  - Issue when (occ + inflight < 2) or shift_en this cycle.
  - On issue: mem_rd_en = 1, mem_addr = counter, counter++, inflight_q = 1 next cycle, otherwise 0.
  - mem_addr holds its last value when no read is issued.
- Skid FIFO:
  - 2 entries.
  - Written with mem_rd_data in the cycle after an issue.
  - Popped by shift_en.
  - Simultaneous write and pop is legal; occ never exceeds 2.
  - No pixel is lost or duplicated under any stall pattern.
- Push:
  - shift_en = (occ != 0) and not stall (combinational in stall).
  - data_out = FIFO head, held stable while stalled.
- Coordinates:
  - col/row give the head pixel's position.
  - On each shift_en, col increments; at WIDTH-1 it wraps to 0 and row increments.
  - After the last pixel, col/row return to 0.
- window_valid = shift_en and row >= 2 and col >= 2. This gives exactly (HEIGHT-2)*(WIDTH-2) pulses per frame.
- Latency and throughput:
  - start sampled at cycle 0: first mem_rd_en at cycle 1, first shift_en at cycle 3.
  - Unstalled frame: shift_en continuous for N cycles, done at cycle N+3.
- Exactly N shift_en pulses per frame, in address order.

Decomposition:
- sobel_pkg holds:
  - feeder state enum (IDLE, RUN, DRAIN, DONE);
  - default frame dimension constants;
  - pixel_t typedef.
- Sub-module pixel_skid_fifo: 2-entry FIFO with wr/rd/occ, parameterised by DATA_WIDTH.

Test Plan (WIDTH=4, HEIGHT=3, mem[i]=i+16):
- Reset check: rst high 2 cycles -> shift_en, mem_rd_en, busy, done, window_valid, col, row all 0.
- Unstalled frame, start at cycle 0 -> mem_rd_en cycles 1..12 with addr 0..11; shift_en cycles 3..14 with data 16..27; window_valid only on data 26 and 27; done=1 only at cycle 15; busy cycles 1..15.
- stall high cycles 5..9 -> no shift_en in 5..9; data_out holds 18; mem_rd_en stops once occ=2; pushed sequence remains 16..27 with no gaps or repeats; done delayed 5 cycles to cycle 20.
- start pulsed again during RUN -> ignored, exactly 12 pushes. start held high through DONE -> new frame issues addr 0 on the cycle after returning to IDLE.
- rst asserted on the cycle of the 6th push -> next cycle shift_en=0, busy=0, occ=0. A following start yields first data 16 at row 0, col 0.
- stall high in DRAIN with occ=1 -> done withheld until the cycle after the final push of data 27.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and default frame geometry for the Sobel row-buffering front end.
package sobel_pkg;

    localparam int DEF_WIDTH      = 100;
    localparam int DEF_HEIGHT     = 100;
    localparam int DEF_DATA_WIDTH = 8;

    typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry skid FIFO between the frame RAM read port and the line-buffer push.
module pixel_skid_fifo #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            occ
);

    logic [1:0][DATA_WIDTH-1:0] mem;
    logic                       wr_ptr;
    logic                       rd_ptr;
    logic                       do_wr;
    logic                       do_rd;

    // A write into a full FIFO is only accepted alongside a pop.
    assign do_rd = rd && (occ != 2'd0);
    assign do_wr = wr && ((occ != 2'd2) || do_rd);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd)
                rd_ptr <= ~rd_ptr;
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/raster_pixel_feeder.sv
// Streams a frame out of a 1-cycle-latency RAM in raster order into the line buffers,
// tracking pixel coordinates and flagging pushes that complete a 3x3 window.
module raster_pixel_feeder
    import sobel_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(WIDTH*HEIGHT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    output logic                      shift_en,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [$clog2(WIDTH)-1:0]  col,
    output logic [$clog2(HEIGHT)-1:0] row,
    output logic                      window_valid,
    output logic                      busy,
    output logic                      done
);

    localparam int N     = WIDTH*HEIGHT;
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    feeder_state_t         state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] addr_last;
    logic                  inflight_q;
    logic [1:0]            occ;
    logic                  room;
    logic                  issue;
    logic                  drained;

    // Room counts reads already in flight so the FIFO can never overflow.
    assign room     = (occ == 2'd0) || ((occ == 2'd1) && !inflight_q);
    assign shift_en = (occ != 2'd0) && !stall;
    assign issue    = (state == ST_RUN) && (room || shift_en);
    assign drained  = !inflight_q &&
                      ((occ == 2'd0) || ((occ == 2'd1) && shift_en));

    assign mem_rd_en    = issue;
    assign mem_addr     = issue ? addr_cnt : addr_last;
    assign window_valid = shift_en && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);

    pixel_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .wr    (inflight_q),
        .wdata (mem_rd_data),
        .rd    (shift_en),
        .rdata (data_out),
        .occ   (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_cnt   <= '0;
            addr_last  <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                addr_last <= addr_cnt;
                addr_cnt  <= addr_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        addr_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (issue && (addr_cnt == ADDR_WIDTH'(N-1)))
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drained)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Coordinates follow the FIFO head; the last pixel wraps both back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (shift_en) begin
            if (col == COL_W'(WIDTH-1)) begin
                col <= '0;
                row <= (row == ROW_W'(HEIGHT-1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule
